// File: rtl/dspl_pkg.sv
// Shared constants and glyph decoder for the eight-digit scan driver.
package dspl_pkg;

  localparam logic [5:0] CODE_DASH = 6'h3F;

  localparam logic [3:0] G_P = 4'hA;
  localparam logic [3:0] G_B = 4'hB;
  localparam logic [3:0] G_C = 4'hC;
  localparam logic [3:0] G_S = 4'hD;
  localparam logic [3:0] G_E = 4'hE;
  localparam logic [3:0] G_U = 4'hF;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'b11111101;

  // Map a 6-bit display code to active-low cathodes {a,b,c,d,e,f,g,dp}.
  function automatic logic [7:0] decode_code(input logic [5:0] code);
    logic [6:0] seg;
    seg = 7'b1111111;
    case (code[4:1])
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      G_P:  seg = 7'b0011000;
      G_B:  seg = 7'b1100000;
      G_C:  seg = 7'b1110010;
      G_S:  seg = 7'b0100100;
      G_E:  seg = 7'b0110000;
      G_U:  seg = 7'b1000001;
      default: seg = 7'b1111111;
    endcase
    if (code == CODE_DASH)
      return SEG_DASH;
    else if (code[5])
      return SEG_BLANK;
    else
      return {seg, ~code[0]};
  endfunction

endpackage

// File: rtl/win_stretch.sv
// Stretches a single-cycle win pulse into a WIN_HOLD-cycle LED indication, retriggerable.
import dspl_pkg::*;

module win_stretch #(
  parameter int WIN_HOLD = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic pulse,
  output logic led
);

  localparam int CW = $clog2(WIN_HOLD + 1);
  localparam logic [CW-1:0] RELOAD = CW'(WIN_HOLD - 1);

  logic [CW-1:0] hold_cnt;

  // Load on pulse, count down while lit, drop the LED the cycle after reaching zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      led      <= 1'b0;
    end else if (pulse) begin
      hold_cnt <= RELOAD;
      led      <= 1'b1;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - CW'(1);
    end else begin
      led      <= 1'b0;
    end
  end

endmodule

// File: rtl/dspl_drv8.sv
// Eight-digit common-anode scan driver with guard time and win LED stretchers.
import dspl_pkg::*;

module dspl_drv8 #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4,
  parameter int WIN_HOLD    = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  input  logic       p1_win,
  input  logic       p2_win,
  output logic [7:0] an,
  output logic [7:0] dec_cat,
  output logic       led_p1,
  output logic       led_p2
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] GUARD_C  = DW'(GUARD);

  logic [DW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [5:0]    cur_code;
  logic [7:0]    an_next;
  logic [7:0]    cat_next;

  // Slot counter and digit index; index advances when the slot counter wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= 3'd0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      idx     <= idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Pick the live (unlatched) code for the digit currently being scanned.
  always_comb begin
    cur_code = d1;
    case (idx)
      3'd0: cur_code = d1;
      3'd1: cur_code = d2;
      3'd2: cur_code = d3;
      3'd3: cur_code = d4;
      3'd4: cur_code = d5;
      3'd5: cur_code = d6;
      3'd6: cur_code = d7;
      3'd7: cur_code = d8;
      default: cur_code = d1;
    endcase
  end

  // Blank everything during the guard window, otherwise drive one anode and its glyph.
  always_comb begin
    an_next  = 8'hFF;
    cat_next = SEG_BLANK;
    if (div_cnt >= GUARD_C) begin
      an_next  = ~(8'h01 << idx);
      cat_next = decode_code(cur_code);
    end
  end

  // Register the display outputs so the pins are glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an      <= 8'hFF;
      dec_cat <= SEG_BLANK;
    end else begin
      an      <= an_next;
      dec_cat <= cat_next;
    end
  end

  win_stretch #(.WIN_HOLD(WIN_HOLD)) u_win_p1 (
    .clock (clock),
    .reset (reset),
    .pulse (p1_win),
    .led   (led_p1)
  );

  win_stretch #(.WIN_HOLD(WIN_HOLD)) u_win_p2 (
    .clock (clock),
    .reset (reset),
    .pulse (p2_win),
    .led   (led_p2)
  );

endmodule

// File: tb/tb_dspl_drv8.sv
// Directed bench for dspl_drv8 with small scan/hold parameters.
module tb_dspl_drv8;

  logic       clock;
  logic       reset;
  logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic       p1_win, p2_win;
  logic [7:0] an, dec_cat;
  logic       led_p1, led_p2;

  int n_vec;
  int n_err;

  typedef struct {
    logic [5:0] code;
    logic [7:0] cat;
  } vec_t;

  vec_t vecs[23];

  dspl_drv8 #(.REFRESH_DIV(8), .GUARD(2), .WIN_HOLD(5)) dut (
    .clock   (clock),
    .reset   (reset),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .d4      (d4),
    .d5      (d5),
    .d6      (d6),
    .d7      (d7),
    .d8      (d8),
    .p1_win  (p1_win),
    .p2_win  (p2_win),
    .an      (an),
    .dec_cat (dec_cat),
    .led_p1  (led_p1),
    .led_p2  (led_p2)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] c1, input logic [5:0] c2,
                               input logic [5:0] c3, input logic [5:0] rest);
    d1 = c1;
    d2 = c2;
    d3 = c3;
    d4 = rest;
    d5 = rest;
    d6 = rest;
    d7 = rest;
    d8 = rest;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_an, exp_cat, one_hot;
    int div, ix;
    bit found;

    n_vec  = 0;
    n_err  = 0;
    reset  = 1'b1;
    p1_win = 1'b0;
    p2_win = 1'b0;
    applyStimulus(6'h3F, 6'h3F, 6'h3F, 6'h3F);

    vecs[0]  = '{6'h00, 8'b00000011};
    vecs[1]  = '{6'h02, 8'b10011111};
    vecs[2]  = '{6'h04, 8'b00100101};
    vecs[3]  = '{6'h06, 8'b00001101};
    vecs[4]  = '{6'h08, 8'b10011001};
    vecs[5]  = '{6'h0A, 8'b01001001};
    vecs[6]  = '{6'h0C, 8'b01000001};
    vecs[7]  = '{6'h0E, 8'b00011111};
    vecs[8]  = '{6'h10, 8'b00000001};
    vecs[9]  = '{6'h12, 8'b00001001};
    vecs[10] = '{6'h14, 8'b00110001};
    vecs[11] = '{6'h16, 8'b11000001};
    vecs[12] = '{6'h18, 8'b11100101};
    vecs[13] = '{6'h1A, 8'b01001001};
    vecs[14] = '{6'h1C, 8'b01100001};
    vecs[15] = '{6'h1E, 8'b10000011};
    vecs[16] = '{6'h01, 8'b00000010};
    vecs[17] = '{6'h11, 8'b00000000};
    vecs[18] = '{6'h1F, 8'b10000010};
    vecs[19] = '{6'h20, 8'hFF};
    vecs[20] = '{6'h2B, 8'hFF};
    vecs[21] = '{6'h3E, 8'hFF};
    vecs[22] = '{6'h3F, 8'b11111101};

    // Reset values while reset is held.
    tick();
    checkOutput("reset_an", an, 8'hFF);
    checkOutput("reset_cat", dec_cat, 8'hFF);
    checkOutput("reset_led_p1", {7'd0, led_p1}, 8'h00);
    checkOutput("reset_led_p2", {7'd0, led_p2}, 8'h00);

    // Full scan: more than one frame with dashes everywhere.
    doReset();
    for (int k = 1; k <= 72; k++) begin
      tick();
      div = (k - 1) % 8;
      ix  = ((k - 1) / 8) % 8;
      one_hot = 8'h01 << ix;
      exp_an  = (div < 2) ? 8'hFF : ~one_hot;
      exp_cat = (div < 2) ? 8'hFF : 8'b11111101;
      checkOutput($sformatf("scan_an_k%0d", k), an, exp_an);
      checkOutput($sformatf("scan_cat_k%0d", k), dec_cat, exp_cat);
    end

    // Distinct digits on the three rightmost positions.
    applyStimulus(6'h00, 6'h02, 6'h01, 6'h3F);
    doReset();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3) begin
        checkOutput("digit_slot0_an", an, 8'hFE);
        checkOutput("digit_slot0_cat", dec_cat, 8'b00000011);
      end
      if (k == 9)  checkOutput("digit_guard1_an", an, 8'hFF);
      if (k == 11) begin
        checkOutput("digit_slot1_an", an, 8'hFD);
        checkOutput("digit_slot1_cat", dec_cat, 8'b10011111);
      end
      if (k == 19) begin
        checkOutput("digit_slot2_an", an, 8'hFB);
        checkOutput("digit_slot2_cat", dec_cat, 8'b00000010);
      end
    end

    // Blank codes in slot 0 and a live code change mid-slot.
    applyStimulus(6'h20, 6'h3F, 6'h3F, 6'h3F);
    doReset();
    tick(); tick(); tick();
    checkOutput("blank20_an", an, 8'hFE);
    checkOutput("blank20_cat", dec_cat, 8'hFF);
    d1 = 6'h2B;
    tick();
    checkOutput("blank2B_cat", dec_cat, 8'hFF);
    d1 = 6'h00;
    tick();
    checkOutput("live_change_an", an, 8'hFE);
    checkOutput("live_change_cat", dec_cat, 8'b00000011);

    // Table-driven glyph decode: every digit gets the same code.
    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].code, vecs[i].code, vecs[i].code, vecs[i].code);
      tick();
      found = 1'b0;
      for (int w = 0; w < 10; w++) begin
        if (an != 8'hFF) begin
          found = 1'b1;
          break;
        end
        tick();
      end
      if (!found) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL glyph_wait_%0d: an stuck at %02h, expected a driven digit", i, an);
      end else begin
        checkOutput($sformatf("glyph_%02h", vecs[i].code), dec_cat, vecs[i].cat);
      end
    end

    // Single p1 pulse: lit for exactly five cycles, p2 untouched.
    p1_win = 1'b1;
    tick();
    p1_win = 1'b0;
    for (int j = 0; j <= 5; j++) begin
      checkOutput($sformatf("p1_single_j%0d", j), {7'd0, led_p1}, (j < 5) ? 8'h01 : 8'h00);
      checkOutput($sformatf("p2_idle_j%0d", j), {7'd0, led_p2}, 8'h00);
      if (j < 5) tick();
    end

    // Retrigger three cycles after the first pulse extends the hold.
    p1_win = 1'b1;
    tick();
    for (int j = 0; j <= 9; j++) begin
      checkOutput($sformatf("p1_retrig_j%0d", j), {7'd0, led_p1}, (j <= 7) ? 8'h01 : 8'h00);
      p1_win = (j == 2);
      tick();
    end
    p1_win = 1'b0;

    // Simultaneous pulses light both LEDs together.
    p1_win = 1'b1;
    p2_win = 1'b1;
    tick();
    p1_win = 1'b0;
    p2_win = 1'b0;
    for (int j = 0; j <= 5; j++) begin
      checkOutput($sformatf("both_p1_j%0d", j), {7'd0, led_p1}, (j < 5) ? 8'h01 : 8'h00);
      checkOutput($sformatf("both_p2_j%0d", j), {7'd0, led_p2}, (j < 5) ? 8'h01 : 8'h00);
      if (j < 5) tick();
    end

    // Reset mid-slot with led_p2 lit, then check the scan restarts from digit 0.
    applyStimulus(6'h3F, 6'h3F, 6'h3F, 6'h3F);
    doReset();
    tick(); tick(); tick();
    p2_win = 1'b1;
    tick();
    p2_win = 1'b0;
    tick();
    checkOutput("pre_reset_led_p2", {7'd0, led_p2}, 8'h01);
    checkOutput("pre_reset_an", an, 8'hFE);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_an", an, 8'hFF);
    checkOutput("async_reset_cat", dec_cat, 8'hFF);
    checkOutput("async_reset_led_p2", {7'd0, led_p2}, 8'h00);
    tick();
    checkOutput("held_reset_an", an, 8'hFF);
    checkOutput("held_reset_led_p2", {7'd0, led_p2}, 8'h00);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("restart_an_k%0d", k), an, (k < 3) ? 8'hFF : 8'hFE);
      checkOutput($sformatf("restart_led_p2_k%0d", k), {7'd0, led_p2}, 8'h00);
    end
    checkOutput("restart_cat", dec_cat, 8'b11111101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
